// File: rtl/maxnet_wta_engine.sv
// Maxnet winner-take-all: iterates a_i -= (sum_{j!=i} a_j) >> EPS_SHIFT with ReLU until one survivor.
// start -> done takes K+2 edges for K updates; start is ignored while busy, accepted in IDLE or DONE.
module maxnet_wta_engine #(
  parameter int N         = 4,
  parameter int W         = 5,
  parameter int EPS_SHIFT = 2,
  parameter int MAX_ITER  = 31
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N*W-1:0]                x_in,
  output logic                          busy,
  output logic                          done,
  output logic [W-1:0]                  result,
  output logic [$clog2(N)-1:0]          winner_idx,
  output logic                          tie,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_ITER+1);
  localparam int SW = W + $clog2(N);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t state, state_nxt;

  logic [N-1:0][W-1:0] x_r, a_r, a_nxt;
  logic [SW-1:0]       tot;
  logic [N-1:0]        nz;
  logic                one_nz;
  logic [IW-1:0]       nz_idx, max_idx;
  logic [W-1:0]        max_val;

  logic                load, step, fin, fin_tie;
  logic [IW-1:0]       fin_idx;

  always_comb begin
    tot = '0;
    for (int i = 0; i < N; i++) tot = tot + SW'(a_r[i]);
  end

  // Sum of the others is the full sum minus self; SW bits cannot overflow.
  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [SW-1:0] inh;
    assign inh      = (tot - SW'(a_r[g])) >> EPS_SHIFT;
    assign nz[g]    = |a_r[g];
    assign a_nxt[g] = (inh >= SW'(a_r[g])) ? '0 : W'(SW'(a_r[g]) - inh);
  end

  assign one_nz = (nz != '0) && ((nz & (nz - N'(1))) == '0);

  always_comb begin
    nz_idx  = '0;
    max_idx = '0;
    max_val = a_r[0];
    for (int i = N-1; i >= 0; i--) begin
      if (nz[i]) nz_idx = IW'(i);
    end
    // Strict compare keeps the lowest index on equal maxima.
    for (int i = 1; i < N; i++) begin
      if (a_r[i] > max_val) begin
        max_val = a_r[i];
        max_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    fin_tie   = 1'b0;
    fin_idx   = '0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ITER;
        end else begin
          state_nxt = IDLE;
        end
      end
      ITER: begin
        if (one_nz) begin
          fin     = 1'b1;
          fin_idx = nz_idx;
        end else if (nz == '0) begin
          fin     = 1'b1;
          fin_tie = 1'b1;
        end else if (iter_count == CW'(MAX_ITER) || a_nxt == a_r) begin
          fin     = 1'b1;
          fin_tie = 1'b1;
          fin_idx = max_idx;
        end else begin
          step = 1'b1;
        end
        if (fin) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r        <= '0;
      a_r        <= '0;
      result     <= '0;
      winner_idx <= '0;
      tie        <= 1'b0;
      iter_count <= '0;
    end else begin
      if (load) begin
        x_r        <= x_in;
        a_r        <= x_in;
        iter_count <= '0;
      end
      if (step) begin
        a_r        <= a_nxt;
        iter_count <= iter_count + CW'(1);
      end
      if (fin) begin
        winner_idx <= fin_idx;
        tie        <= fin_tie;
        result     <= x_r[fin_idx];
      end
    end
  end

  assign busy = (state == ITER);
  assign done = (state == DONE);

endmodule
